// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues req/ack word reads to instruction
// memory, and buffers {instr, pc} in a small FIFO with valid/ready output.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_incpc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QD_C = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state_r;
  logic [31:0]     fetch_pc_r;
  logic            imem_req_r;
  logic [31:0]     imem_addr_r;
  logic [CW-1:0]   count_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [31:0]     instr_mem_r [QDEPTH];
  logic [31:0]     pc_mem_r    [QDEPTH];
  logic            out_valid_r;
  logic [31:0]     out_instr_r;
  logic [31:0]     out_pc_r;

  state_t          state_next_s;
  logic            push_s;
  logic            pop_s;
  logic [CW-1:0]   count_next_s;
  logic [PW-1:0]   rd_ptr_next_s;
  logic [PW-1:0]   wr_ptr_next_s;
  logic [31:0]     fetch_pc_next_s;
  logic [31:0]     imem_addr_next_s;
  logic            head_hit_s;
  logic [31:0]     head_instr_next_s;
  logic [31:0]     head_pc_next_s;

  // Next-state, FIFO bookkeeping and next head-entry computation
  always_comb begin
    pop_s  = out_valid_r & out_ready;
    push_s = (state_r == REQ) & imem_ack & ~redirect;

    if (redirect) begin
      count_next_s    = {CW{1'b0}};
      rd_ptr_next_s   = {PW{1'b0}};
      wr_ptr_next_s   = {PW{1'b0}};
      fetch_pc_next_s = {redirect_pc[31:2], 2'b00};
    end else begin
      count_next_s    = count_r + CW'(push_s) - CW'(pop_s);
      rd_ptr_next_s   = pop_s  ? rd_ptr_r + PW'(1) : rd_ptr_r;
      wr_ptr_next_s   = push_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
      fetch_pc_next_s = push_s ? fetch_pc_r + 32'd4 : fetch_pc_r;
    end

    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          state_next_s = REQ;
        end else if (count_next_s < QD_C) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        // An un-acked request cannot be withdrawn, so a redirect parks in DROP
        if (redirect) begin
          state_next_s = imem_ack ? REQ : DROP;
        end else if (imem_ack) begin
          state_next_s = (count_next_s < QD_C) ? REQ : IDLE;
        end else begin
          state_next_s = REQ;
        end
      end
      DROP: begin
        if (redirect) begin
          state_next_s = DROP;
        end else if (imem_ack) begin
          state_next_s = REQ;
        end else begin
          state_next_s = DROP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    imem_addr_next_s = (state_next_s == DROP) ? imem_addr_r : fetch_pc_next_s;

    // The head after this edge may be the word being written right now
    head_hit_s = push_s & (wr_ptr_r == rd_ptr_next_s);
    if (head_hit_s) begin
      head_instr_next_s = imem_rdata;
      head_pc_next_s    = fetch_pc_r;
    end else begin
      head_instr_next_s = instr_mem_r[rd_ptr_next_s];
      head_pc_next_s    = pc_mem_r[rd_ptr_next_s];
    end
  end

  // Control state, fetch PC, memory request and registered output head
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      fetch_pc_r  <= RESET_PC;
      imem_req_r  <= 1'b0;
      imem_addr_r <= RESET_PC;
      count_r     <= {CW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      out_valid_r <= 1'b0;
      out_instr_r <= 32'h0000_0000;
      out_pc_r    <= 32'h0000_0000;
    end else begin
      state_r     <= state_next_s;
      fetch_pc_r  <= fetch_pc_next_s;
      imem_req_r  <= (state_next_s != IDLE);
      imem_addr_r <= imem_addr_next_s;
      count_r     <= count_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      out_valid_r <= (count_next_s != {CW{1'b0}});
      out_instr_r <= head_instr_next_s;
      out_pc_r    <= head_pc_next_s;
    end
  end

  // FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= 32'h0000_0000;
      end
    end else if (push_s) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign out_valid = out_valid_r;
  assign out_instr = out_instr_r;
  assign out_pc    = out_pc_r;
  assign out_incpc = out_pc_r + 32'd4;

  instr_fetch_chk #(
    .QDEPTH(QDEPTH),
    .CW    (CW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .imem_req (imem_req_r),
    .imem_ack (imem_ack),
    .imem_addr(imem_addr_r),
    .count    (count_r),
    .in_req   (state_r == REQ)
  );

endmodule

// Protocol and occupancy invariants of the fetch stage.
module instr_fetch_chk #(
  parameter int QDEPTH = 4,
  parameter int CW     = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_req,
  input logic          imem_ack,
  input logic [31:0]   imem_addr,
  input logic [CW-1:0] count,
  input logic          in_req
);

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_ack) |=> $stable(imem_addr));

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
    imem_addr[1:0] == 2'b00);

  a_slot_reserved: assert property (@(posedge clk) disable iff (!rst)
    (int'(count) + int'(in_req)) <= QDEPTH);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected PCs; a second
// instance checks PC wrap-around with a high reset address.
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_incpc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        ack_tie;
  logic        ack_man;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_incpc;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  logic [31:0] sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_ack   = ack_tie ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ KEY;

  assign w_ack         = w_req;
  assign w_rdata       = w_addr ^ KEY;
  assign w_ready       = 1'b1;
  assign w_redirect    = 1'b0;
  assign w_redirect_pc = 32'h0000_0000;

  instr_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_incpc(out_incpc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .out_valid(w_valid), .out_ready(w_ready), .out_instr(w_instr),
    .out_pc(w_pc), .out_incpc(w_incpc),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the head against the scoreboard if it is consumed at the coming edge
  task automatic step();
    logic [31:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_output observed=%h expected=none", out_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_pc", out_pc, e);
        chk("pop_instr", out_instr, e ^ KEY);
        chk("pop_incpc", out_incpc, e + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    ack_tie     = 1'b0;
    ack_man     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    out_ready   = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic ack_after(input int n);
    repeat (n - 1) step();
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ack_tie = 1'b0; ack_man = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0000_0000; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h0000_0000);
    chk("rst_pc", out_pc, 32'h0000_0000);
    chk("rst_incpc", out_incpc, 32'h0000_0004);
    chk("rst_addr", imem_addr, 32'h0000_0000);

    // Streaming: ack every cycle, always ready
    do_reset();
    chk("t1_idle_req", 32'(imem_req), 32'd0);
    ack_tie = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back(32'(i) * 32'd4);
    step();
    chk("t1_c1_req", 32'(imem_req), 32'd1);
    chk("t1_c1_addr", imem_addr, 32'h0000_0000);
    chk("t1_c1_valid", 32'(out_valid), 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", 32'(out_valid), 32'd1);
      step();
    end
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure: fill exactly four, then drain and resume at 0x10
    do_reset();
    ack_tie = 1'b1;
    repeat (5) step();
    chk("t2_full_req", 32'(imem_req), 32'd0);
    chk("t2_full_addr", imem_addr, 32'h0000_0010);
    chk("t2_full_valid", 32'(out_valid), 32'd1);
    step(); step();
    chk("t2_hold_req", 32'(imem_req), 32'd0);
    chk("t2_hold_addr", imem_addr, 32'h0000_0010);
    for (int i = 0; i < 5; i++) sb.push_back(32'(i) * 32'd4);
    out_ready = 1'b1;
    step();
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h0000_0010);
    repeat (4) step();
    out_ready = 1'b0;
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Slow memory with redirect while 0x8 is outstanding
    do_reset();
    out_ready = 1'b1;
    step();
    chk("t3_addr0", imem_addr, 32'h0000_0000);
    sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0004);
    ack_after(3);
    ack_after(3);
    chk("t3_addr8", imem_addr, 32'h0000_0008);
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    chk("t3_drop_valid", 32'(out_valid), 32'd0);
    chk("t3_drop_req", 32'(imem_req), 32'd1);
    chk("t3_drop_addr", imem_addr, 32'h0000_0008);
    step();
    chk("t3_drop_addr2", imem_addr, 32'h0000_0008);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    chk("t3_target_addr", imem_addr, 32'h0000_0200);
    chk("t3_target_valid", 32'(out_valid), 32'd0);
    sb.push_back(32'h0000_0200);
    ack_after(2);
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    step();
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Redirect together with an ack and a pop, three entries queued
    do_reset();
    ack_tie = 1'b1;
    repeat (4) step();
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_addr", imem_addr, 32'h0000_000C);
    sb.push_back(32'h0000_0000);
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_1000;
    step();
    redirect = 1'b0; ack_tie = 1'b0;
    chk("t4_flush_valid", 32'(out_valid), 32'd0);
    chk("t4_flush_req", 32'(imem_req), 32'd1);
    chk("t4_flush_addr", imem_addr, 32'h0000_1000);
    sb.push_back(32'h0000_1000);
    ack_tie = 1'b1;
    step();
    chk("t4_target_valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b0;
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // PC wrap-around on the high-reset-address instance
    do_reset();
    step();
    chk("t5_req", 32'(w_req), 32'd1);
    chk("t5_addr", w_addr, 32'hFFFF_FFF8);
    chk("t5_valid0", 32'(w_valid), 32'd0);
    step();
    chk("t5_pc0", w_pc, 32'hFFFF_FFF8);
    chk("t5_instr0", w_instr, 32'hFFFF_FFF8 ^ KEY);
    step();
    chk("t5_pc1", w_pc, 32'hFFFF_FFFC);
    chk("t5_incpc1", w_incpc, 32'h0000_0000);
    step();
    chk("t5_pc2", w_pc, 32'h0000_0000);
    chk("t5_incpc2", w_incpc, 32'h0000_0004);
    chk("t5_valid2", 32'(w_valid), 32'd1);

    // Asynchronous reset mid-fetch: with queued entries, then with DROP pending
    do_reset();
    step();
    ack_man = 1'b1;
    step(); step();
    ack_man = 1'b0;
    chk("t6_valid_pre", 32'(out_valid), 32'd1);
    chk("t6_addr_pre", imem_addr, 32'h0000_0008);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_pc", out_pc, 32'h0000_0000);
    chk("t6_rst_instr", out_instr, 32'h0000_0000);
    chk("t6_rst_incpc", out_incpc, 32'h0000_0004);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    chk("t6_restart_addr", imem_addr, 32'h0000_0000);
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    step();
    redirect = 1'b0;
    chk("t6_drop_addr", imem_addr, 32'h0000_0000);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst2_req", 32'(imem_req), 32'd0);
    chk("t6_rst2_addr", imem_addr, 32'h0000_0000);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    chk("t6_restart2_req", 32'(imem_req), 32'd1);
    chk("t6_restart2_addr", imem_addr, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
